// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and the shared coordinate type.
// Sync windows are half-open ranges [START, END) in pixels and lines.
package vga_timing_pkg;
   localparam int CNT_W     = 10;
   localparam int H_VISIBLE = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int V_VISIBLE = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;
   localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int HS_START  = H_VISIBLE + H_FRONT;
   localparam int HS_END    = HS_START + H_SYNC;
   localparam int VS_START  = V_VISIBLE + V_FRONT;
   localparam int VS_END    = VS_START + V_SYNC;

   typedef logic [CNT_W-1:0] vga_coord_t;
endpackage

// File: rtl/vga_timing_if.sv
// Pixel-scan bus: the timing generator is the master, draw/render blocks are slaves.
// swap_req is the only renderer-driven signal; it is a level held until swap_ack.
interface vga_timing_if #(
   parameter int CNT_W = vga_timing_pkg::CNT_W
);
   logic             hs;
   logic             vs;
   logic             blank;
   logic [CNT_W-1:0] DrawX;
   logic [CNT_W-1:0] DrawY;
   logic             vblank_start;
   logic             swap_req;
   logic             swap_ack;
   logic             front_buf;
   logic [15:0]      frame_count;

   modport master (
      output hs, vs, blank, DrawX, DrawY, vblank_start, swap_ack, front_buf, frame_count,
      input  swap_req
   );
   modport slave (
      input  hs, vs, blank, DrawX, DrawY, vblank_start, swap_ack, front_buf, frame_count,
      output swap_req
   );
endinterface

// File: rtl/vga_timing_gen_axis_ctr.sv
// One scan axis: wrapping counter with sync registered from the next count, 0-cycle skew to cnt.
// No backpressure: advances whenever inc is high; vis_nxt is the combinational next-visible decode.
module vga_axis_ctr #(
   parameter int VISIBLE  = 640,
   parameter int FRONT    = 16,
   parameter int SYNC     = 96,
   parameter int BACK     = 48,
   parameter bit SYNC_POL = 1'b0,
   parameter int CNT_W    = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt,
   output logic             wrap,
   output logic             vis_nxt,
   output logic             sync
);
   localparam logic [CNT_W-1:0] LAST    = CNT_W'(VISIBLE + FRONT + SYNC + BACK - 1);
   localparam logic [CNT_W-1:0] VIS_END = CNT_W'(VISIBLE);
   localparam logic [CNT_W-1:0] S_START = CNT_W'(VISIBLE + FRONT);
   localparam logic [CNT_W-1:0] S_END   = CNT_W'(VISIBLE + FRONT + SYNC);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sync_q, sync_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
      vis_nxt = (cnt_d < VIS_END);
      sync_d  = ((cnt_d >= S_START) && (cnt_d < S_END)) ? SYNC_POL : ~SYNC_POL;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         sync_q <= ~SYNC_POL;
      end else begin
         cnt_q  <= cnt_d;
         sync_q <= sync_d;
      end
   end

   assign cnt  = cnt_q;
   assign wrap = inc && (cnt_q == LAST);
   assign sync = sync_q;
endmodule

// File: rtl/vga_timing_gen.sv
// Scan timing source: counters, blank/sync, vblank strobe and vblank-only buffer swap; all outputs flops.
// Latency: every output describes the (DrawX,DrawY) of the same cycle; no backpressure, swap_req is a held level.
module vga_timing_gen #(
   parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
   parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
   parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
   parameter int H_BACK    = vga_timing_pkg::H_BACK,
   parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
   parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
   parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
   parameter int V_BACK    = vga_timing_pkg::V_BACK,
   parameter bit SYNC_POL  = 1'b0,
   parameter int CNT_W     = vga_timing_pkg::CNT_W
) (
   input  logic           vga_clk,
   input  logic           reset_n,
   vga_timing_if.master   bus
);
   if ((H_VISIBLE + H_FRONT + H_SYNC + H_BACK > (1 << CNT_W)) ||
       (V_VISIBLE + V_FRONT + V_SYNC + V_BACK > (1 << CNT_W))) begin : g_cnt_w_chk
      $error("vga_timing_gen: CNT_W cannot hold the line/frame totals");
   end

   localparam logic [CNT_W-1:0] VB_PREV_LINE = CNT_W'(V_VISIBLE - 1);

   logic [CNT_W-1:0] h_cnt, v_cnt;
   logic             h_wrap, v_wrap_unused;
   logic             h_vis_nxt, v_vis_nxt;
   logic             hs_q, vs_q;

   vga_axis_ctr #(
      .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
      .SYNC_POL(SYNC_POL), .CNT_W(CNT_W)
   ) u_h_ctr (
      .clk(vga_clk), .rst_n(reset_n), .inc(1'b1),
      .cnt(h_cnt), .wrap(h_wrap), .vis_nxt(h_vis_nxt), .sync(hs_q)
   );

   vga_axis_ctr #(
      .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
      .SYNC_POL(SYNC_POL), .CNT_W(CNT_W)
   ) u_v_ctr (
      .clk(vga_clk), .rst_n(reset_n), .inc(h_wrap),
      .cnt(v_cnt), .wrap(v_wrap_unused), .vis_nxt(v_vis_nxt), .sync(vs_q)
   );

   logic        blank_q, blank_d;
   logic        vblank_q, vblank_d;
   logic        swap_ack_q, swap_ack_d;
   logic        front_buf_q, front_buf_d;
   logic [15:0] frame_count_q, frame_count_d;

   // The edge that lands on (0,V_VISIBLE) is the vblank edge; swap_req is taken at that edge
   // so the flip and its ack appear together with vblank_start.
   always_comb begin
      blank_d       = h_vis_nxt & v_vis_nxt;
      vblank_d      = h_wrap && (v_cnt == VB_PREV_LINE);
      swap_ack_d    = vblank_d & bus.swap_req;
      front_buf_d   = front_buf_q ^ swap_ack_d;
      frame_count_d = vblank_d ? frame_count_q + 16'd1 : frame_count_q;
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         blank_q       <= 1'b1;
         vblank_q      <= 1'b0;
         swap_ack_q    <= 1'b0;
         front_buf_q   <= 1'b0;
         frame_count_q <= '0;
      end else begin
         blank_q       <= blank_d;
         vblank_q      <= vblank_d;
         swap_ack_q    <= swap_ack_d;
         front_buf_q   <= front_buf_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign bus.DrawX        = h_cnt;
   assign bus.DrawY        = v_cnt;
   assign bus.hs           = hs_q;
   assign bus.vs           = vs_q;
   assign bus.blank        = blank_q;
   assign bus.vblank_start = vblank_q;
   assign bus.swap_ack     = swap_ack_q;
   assign bus.front_buf    = front_buf_q;
   assign bus.frame_count  = frame_count_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance for line timing, a 14x7 instance for frame/swap behaviour.
module tb_vga_timing_gen;
   import vga_timing_pkg::*;

   logic vga_clk = 1'b0;
   logic reset_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 vga_clk = ~vga_clk;

   vga_timing_if #(.CNT_W(10)) bus_def ();
   vga_timing_if #(.CNT_W(10)) bus_sm ();

   vga_timing_gen dut_def (.vga_clk(vga_clk), .reset_n(reset_n), .bus(bus_def));

   vga_timing_gen #(
      .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
      .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
      .SYNC_POL(1'b1), .CNT_W(10)
   ) dut_sm (.vga_clk(vga_clk), .reset_n(reset_n), .bus(bus_sm));

   task automatic tick();
      @(posedge vga_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_vb(output int early);
      early = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (bus_sm.vblank_start === 1'b1) return;
         if (bus_sm.swap_ack === 1'b1) early++;
      end
      chk("vblank_timeout", 32'(bus_sm.vblank_start), 32'd1);
   endtask

   task automatic wait_sm_y(input int y);
      for (int i = 0; i < 200; i++) begin
         if (bus_sm.DrawY === 10'(y)) return;
         tick();
      end
      chk("wait_y_timeout", 32'(bus_sm.DrawY), 32'(y));
   endtask

   initial begin
      vga_coord_t x_seen;
      int first_blank, hs_lo, hs_first, hs_last, seq_err, blank_err, vs_err;
      int mx, my, vb, vb_pos_err, vs_hi, hs_err, pos_err, fc_err;
      int early;

      reset_n = 1'b0;
      bus_def.swap_req = 1'b0;
      bus_sm.swap_req  = 1'b0;
      tick();
      tick();

      // Reset state on both instances
      chk("rst_x", 32'(bus_def.DrawX), 0);
      chk("rst_y", 32'(bus_def.DrawY), 0);
      chk("rst_blank", 32'(bus_def.blank), 1);
      chk("rst_hs", 32'(bus_def.hs), 1);
      chk("rst_vs", 32'(bus_def.vs), 1);
      chk("rst_vblank", 32'(bus_def.vblank_start), 0);
      chk("rst_ack", 32'(bus_def.swap_ack), 0);
      chk("rst_front", 32'(bus_def.front_buf), 0);
      chk("rst_fc", 32'(bus_def.frame_count), 0);
      chk("rst_sm_hs", 32'(bus_sm.hs), 0);
      chk("rst_sm_vs", 32'(bus_sm.vs), 0);

      reset_n = 1'b1;
      chk("c0_x", 32'(bus_def.DrawX), 0);
      chk("c0_blank", 32'(bus_def.blank), 1);
      tick();
      chk("c1_x", 32'(bus_def.DrawX), 1);
      chk("c1_y", 32'(bus_def.DrawY), 0);
      repeat (799) tick();
      chk("line_wrap_x", 32'(bus_def.DrawX), 0);
      chk("line_wrap_y", 32'(bus_def.DrawY), 1);

      // One full default line (DrawY=1)
      first_blank = -1; hs_lo = 0; hs_first = -1; hs_last = -1;
      seq_err = 0; blank_err = 0; vs_err = 0;
      for (int i = 0; i < 800; i++) begin
         x_seen = bus_def.DrawX;
         if (x_seen !== 10'(i)) seq_err++;
         if (bus_def.blank !== (i < 640)) blank_err++;
         if (bus_def.vs !== 1'b1) vs_err++;
         if (bus_def.hs === 1'b0) begin
            hs_lo++;
            if (hs_first < 0) hs_first = i;
            hs_last = i;
         end
         if (bus_def.blank === 1'b0 && first_blank < 0) first_blank = i;
         tick();
      end
      chk("line_seq_err", 32'(seq_err), 0);
      chk("line_blank_err", 32'(blank_err), 0);
      chk("line_vs_err", 32'(vs_err), 0);
      chk("blank_fall_x", 32'(first_blank), 640);
      chk("hs_low_cycles", 32'(hs_lo), 96);
      chk("hs_first_x", 32'(hs_first), 656);
      chk("hs_last_x", 32'(hs_last), 751);

      // Small-mode full frame
      reset_n = 1'b0;
      tick();
      chk("sm_rst_blank", 32'(bus_sm.blank), 1);
      reset_n = 1'b1;
      mx = 0; my = 0; vb = 0; vb_pos_err = 0; vs_hi = 0;
      hs_err = 0; pos_err = 0; fc_err = 0; blank_err = 0; vs_err = 0;
      for (int i = 0; i < 98; i++) begin
         if (bus_sm.DrawX !== 10'(mx) || bus_sm.DrawY !== 10'(my)) pos_err++;
         if (bus_sm.hs !== (mx >= 10 && mx <= 11)) hs_err++;
         if (bus_sm.vs !== (my == 5)) vs_err++;
         if (bus_sm.vs === 1'b1) vs_hi++;
         if (bus_sm.blank !== (mx < 8 && my < 4)) blank_err++;
         if (bus_sm.vblank_start === 1'b1) begin
            vb++;
            if (!(mx == 0 && my == 4)) vb_pos_err++;
         end
         if (bus_sm.frame_count !== 16'(vb)) fc_err++;
         tick();
         mx++;
         if (mx == 14) begin
            mx = 0;
            my = (my == 6) ? 0 : my + 1;
         end
      end
      chk("sm_pos_err", 32'(pos_err), 0);
      chk("sm_hs_err", 32'(hs_err), 0);
      chk("sm_vs_err", 32'(vs_err), 0);
      chk("sm_vs_high", 32'(vs_hi), 14);
      chk("sm_blank_err", 32'(blank_err), 0);
      chk("sm_vb_count", 32'(vb), 1);
      chk("sm_vb_pos", 32'(vb_pos_err), 0);
      chk("sm_fc_err", 32'(fc_err), 0);
      chk("sm_wrap_x", 32'(bus_sm.DrawX), 0);
      chk("sm_wrap_y", 32'(bus_sm.DrawY), 0);
      chk("sm_fc1", 32'(bus_sm.frame_count), 1);

      // Swap request held from DrawY=1 until ack
      wait_sm_y(1);
      bus_sm.swap_req = 1'b1;
      wait_vb(early);
      chk("swap1_early", 32'(early), 0);
      chk("swap1_ack", 32'(bus_sm.swap_ack), 1);
      chk("swap1_front", 32'(bus_sm.front_buf), 1);
      chk("swap1_fc", 32'(bus_sm.frame_count), 2);
      tick();
      chk("swap1_ack_drop", 32'(bus_sm.swap_ack), 0);
      bus_sm.swap_req = 1'b0;
      wait_vb(early);
      chk("noreq_ack", 32'(bus_sm.swap_ack), 0);
      chk("noreq_front", 32'(bus_sm.front_buf), 1);

      // Short pulse between vblanks is forgotten
      wait_sm_y(2);
      bus_sm.swap_req = 1'b1;
      repeat (3) tick();
      bus_sm.swap_req = 1'b0;
      wait_vb(early);
      chk("pulse_early", 32'(early), 0);
      chk("pulse_ack", 32'(bus_sm.swap_ack), 0);
      chk("pulse_front", 32'(bus_sm.front_buf), 1);
      chk("pulse_fc", 32'(bus_sm.frame_count), 4);

      // Reset mid-frame with a pending request
      wait_sm_y(3);
      bus_sm.swap_req = 1'b1;
      repeat (2) tick();
      reset_n = 1'b0;
      #1;
      chk("mid_rst_x", 32'(bus_sm.DrawX), 0);
      chk("mid_rst_y", 32'(bus_sm.DrawY), 0);
      chk("mid_rst_front", 32'(bus_sm.front_buf), 0);
      chk("mid_rst_fc", 32'(bus_sm.frame_count), 0);
      chk("mid_rst_ack", 32'(bus_sm.swap_ack), 0);
      chk("mid_rst_hs", 32'(bus_sm.hs), 0);
      chk("mid_rst_def_x", 32'(bus_def.DrawX), 0);
      bus_sm.swap_req = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      chk("restart_x", 32'(bus_sm.DrawX), 1);
      chk("restart_y", 32'(bus_sm.DrawY), 0);
      wait_vb(early);
      chk("post_rst_ack", 32'(bus_sm.swap_ack), 0);
      chk("post_rst_front", 32'(bus_sm.front_buf), 0);
      chk("post_rst_fc", 32'(bus_sm.frame_count), 1);

      // Request left high across two vblanks flips twice
      bus_sm.swap_req = 1'b1;
      wait_vb(early);
      chk("hold1_ack", 32'(bus_sm.swap_ack), 1);
      chk("hold1_front", 32'(bus_sm.front_buf), 1);
      wait_vb(early);
      chk("hold2_early", 32'(early), 0);
      chk("hold2_ack", 32'(bus_sm.swap_ack), 1);
      chk("hold2_front", 32'(bus_sm.front_buf), 0);
      chk("hold2_fc", 32'(bus_sm.frame_count), 3);
      bus_sm.swap_req = 1'b0;

      // frame_count wrap 0xFFFF -> 0
      force dut_sm.frame_count_q = 16'hFFFF;
      #1;
      release dut_sm.frame_count_q;
      chk("fc_preset", 32'(bus_sm.frame_count), 32'hFFFF);
      wait_vb(early);
      chk("fc_wrap", 32'(bus_sm.frame_count), 0);
      tick();
      chk("fc_hold", 32'(bus_sm.frame_count), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
